// File: rtl/axis_stream_joiner.sv
// N-channel AXI-Stream join: each input has a 2-entry skid buffer, enabled channels merge into
// one registered output beat. Per-packet channel mask, sticky tlast-disagreement flag, counters.
module axis_stream_joiner #(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TUSER_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_CH-1:0]            ch_enable,
    input  logic [N_CH-1:0]            s_axis_tvalid,
    output logic [N_CH-1:0]            s_axis_tready,
    input  logic [N_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]            s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0]     s_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [N_CH*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [N_CH-1:0]            active_mask,
    output logic                       err_tlast,
    output logic [CNT_WIDTH-1:0]       beat_count,
    output logic [CNT_WIDTH-1:0]       pkt_count
);
    // Buffer entry layout: {data, last, user}
    localparam int unsigned EW = DATA_WIDTH + 1 + TUSER_WIDTH;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                     state_q, state_d;
    logic [EW-1:0]              head_q [N_CH];
    logic [EW-1:0]              head_d [N_CH];
    logic [EW-1:0]              tail_q [N_CH];
    logic [EW-1:0]              tail_d [N_CH];
    logic [EW-1:0]              in_e   [N_CH];
    logic [1:0]                 cnt_q  [N_CH];
    logic [1:0]                 cnt_d  [N_CH];
    logic [N_CH-1:0]            rdy_q, rdy_d, mask_q, mask_d;
    logic [N_CH-1:0]            eff_mask, eff_mask_d, push, pop, head_last;
    logic                       vld_q, vld_d, last_q, last_d, err_q, err_d;
    logic [N_CH*DATA_WIDTH-1:0] data_q, data_d;
    logic [TUSER_WIDTH-1:0]     user_q, user_d;
    logic [CNT_WIDTH-1:0]       beat_q, beat_d, pkt_q, pkt_d;
    logic                       all_avail, fire, out_hs, any_last, all_last;

    always_comb begin
        eff_mask  = (state_q == StRun) ? mask_q : ch_enable;
        all_avail = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            head_last[i] = head_q[i][TUSER_WIDTH];
            if (eff_mask[i] && (cnt_q[i] == 2'd0)) all_avail = 1'b0;
        end
        fire     = all_avail && (eff_mask != '0) && (!vld_q || m_axis_tready);
        out_hs   = vld_q && m_axis_tready;
        push     = s_axis_tvalid & rdy_q;
        pop      = fire ? eff_mask : '0;
        any_last = |(head_last & eff_mask);
        all_last = &(head_last | ~eff_mask);

        // Per-channel skid buffer: head is the oldest entry
        for (int i = 0; i < N_CH; i++) begin
            in_e[i]   = {s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH], s_axis_tlast[i], s_axis_tuser};
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
            unique case ({push[i], pop[i]})
                2'b10: begin
                    if (cnt_q[i] == 2'd0) head_d[i] = in_e[i];
                    else                  tail_d[i] = in_e[i];
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end
                2'b01: begin
                    head_d[i] = tail_q[i];
                    cnt_d[i]  = cnt_q[i] - 2'd1;
                end
                2'b11: begin
                    if (cnt_q[i] == 2'd1) begin
                        head_d[i] = in_e[i];
                    end else begin
                        head_d[i] = tail_q[i];
                        tail_d[i] = in_e[i];
                    end
                end
                default: ;
            endcase
        end

        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        user_d = user_q;
        if (fire) begin
            vld_d  = 1'b1;
            last_d = any_last;
            user_d = eff_mask[0] ? head_q[0][TUSER_WIDTH-1:0] : '0;
            for (int i = 0; i < N_CH; i++) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                    eff_mask[i] ? head_q[i][EW-1 -: DATA_WIDTH] : '0;
            end
        end else if (out_hs) begin
            vld_d  = 1'b0;
            data_d = '0;
            last_d = 1'b0;
            user_d = '0;
        end
        err_d = err_q | (fire & any_last & ~all_last);

        state_d = state_q;
        mask_d  = mask_q;
        if (fire) begin
            if (state_q == StIdle) mask_d = ch_enable;
            state_d = any_last ? StIdle : StRun;
        end
        // Ready is registered, so it is computed from the state the next cycle will see
        eff_mask_d = (state_d == StRun) ? mask_d : ch_enable;
        for (int i = 0; i < N_CH; i++) begin
            rdy_d[i] = (cnt_d[i] != 2'd2) && eff_mask_d[i];
        end

        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (out_hs) begin
            if (last_q) begin
                beat_d = '0;
                pkt_d  = pkt_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            mask_q  <= '0;
            rdy_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            pkt_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            for (int i = 0; i < N_CH; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign s_axis_tready = rdy_q;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign active_mask   = mask_q;
    assign err_tlast     = err_q;
    assign beat_count    = beat_q;
    assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_stream_joiner.sv
// Randomised bench for axis_stream_joiner: per-channel source queues feed a driver, a monitor
// joins the accepted beats per packet mask and compares against every output handshake.
module tb_axis_stream_joiner;
    localparam int N_CH = 3;
    localparam int DW   = 64;
    localparam int UW   = 8;
    localparam int CW   = 32;
    localparam int TW   = N_CH * DW;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N_CH-1:0]   ch_enable, s_axis_tvalid, s_axis_tready, s_axis_tlast, active_mask;
    logic [TW-1:0]     s_axis_tdata, m_axis_tdata;
    logic [UW-1:0]     s_axis_tuser, m_axis_tuser;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, err_tlast;
    logic [CW-1:0]     beat_count, pkt_count;

    always #5 aclk = ~aclk;

    axis_stream_joiner #(
        .N_CH(N_CH), .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .ch_enable(ch_enable),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .active_mask(active_mask), .err_tlast(err_tlast),
        .beat_count(beat_count), .pkt_count(pkt_count)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    beat_t           src_q  [N_CH][$];  // beats waiting to be offered
    beat_t           exp_in [N_CH][$];  // beats accepted by the DUT, not yet seen at the output
    logic [N_CH-1:0] mask_q [$];        // expected channel mask of each upcoming packet
    int              vprob [N_CH];
    int              rprob;
    int              cyc, cap1, first_v, hs_first, hs_last;
    bit              rdy1_seen;
    int              tests, fails;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int ch, input bit last);
        beat_t b;
        b.d = {$urandom, $urandom};
        b.l = last;
        b.u = UW'($urandom);
        src_q[ch].push_back(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 5000 && !(src_q[0].size() == 0 && src_q[1].size() == 0 &&
               src_q[2].size() == 0 && exp_in[0].size() == 0 && exp_in[1].size() == 0 &&
               exp_in[2].size() == 0 && mask_q.size() == 0 && !m_axis_tvalid)) begin
            @(negedge aclk); #2;
            n++;
        end
        chk({name, "_drain_timeout"}, TW'(n >= 5000), '0);
    endtask

    // Driver: offers beats at the falling edge, retires them at the rising edge on handshake
    initial begin : driver
        bit hs   [N_CH];
        bit pres [N_CH];
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;
        cyc = 0;
        for (int c = 0; c < N_CH; c++) pres[c] = 0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                for (int c = 0; c < N_CH; c++) begin
                    pres[c] = 0;
                    hs[c]   = 0;
                end
                s_axis_tvalid = '0;
                m_axis_tready = 1'b0;
                continue;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (!pres[c] && src_q[c].size() > 0 && $urandom_range(99) < vprob[c])
                    pres[c] = 1;
                s_axis_tvalid[c] = pres[c];
                if (pres[c]) begin
                    s_axis_tdata[c*DW +: DW] = src_q[c][0].d;
                    s_axis_tlast[c]          = src_q[c][0].l;
                    if (c == 0) s_axis_tuser = src_q[0][0].u;
                end else if (c == 0) begin
                    s_axis_tuser = UW'($urandom);
                end
                hs[c] = pres[c] && s_axis_tready[c];
            end
            m_axis_tready = ($urandom_range(99) < rprob);
            @(posedge aclk);
            if (aresetn) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (hs[c]) begin
                        exp_in[c].push_back(src_q[c].pop_front());
                        pres[c] = 0;
                        if (c == 1 && cap1 < 0) cap1 = cyc;
                    end
                end
            end
        end
    end

    // Monitor: joins the oldest accepted beat of every channel in the packet's mask
    initial begin : monitor
        logic [N_CH-1:0] pm;
        logic [TW-1:0]   ed, sd;
        logic [UW-1:0]   eu, su;
        logic            el, sl, anyl, alll;
        bit              open, stall, err_m;
        int              bidx, pkts;
        beat_t           b;
        open = 0; stall = 0; err_m = 0; bidx = 0; pkts = 0; pm = '0;
        forever begin
            @(negedge aclk); #1;
            if (!aresetn) begin
                open = 0; stall = 0; err_m = 0; bidx = 0; pkts = 0;
                continue;
            end
            if (s_axis_tready[1]) rdy1_seen = 1;
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (stall) begin
                chk("stall_valid", TW'(m_axis_tvalid), TW'(1));
                chk("stall_data", m_axis_tdata, sd);
                chk("stall_last", TW'(m_axis_tlast), TW'(sl));
                chk("stall_user", TW'(m_axis_tuser), TW'(su));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                if (!open) begin
                    if (mask_q.size() == 0) begin
                        chk("unexpected_output_beat", TW'(1), TW'(0));
                        pm = '0;
                    end else begin
                        pm = mask_q.pop_front();
                    end
                    open = 1;
                    bidx = 0;
                end
                ed = '0; eu = '0; anyl = 0; alll = 1;
                for (int c = 0; c < N_CH; c++) begin
                    if (pm[c]) begin
                        if (exp_in[c].size() == 0) begin
                            chk("output_without_input", TW'(c + 1), TW'(0));
                        end else begin
                            b = exp_in[c].pop_front();
                            ed[c*DW +: DW] = b.d;
                            anyl = anyl | b.l;
                            alll = alll & b.l;
                            if (c == 0) eu = b.u;
                        end
                    end
                end
                el = anyl;
                if (anyl && !alll) err_m = 1;
                chk("out_tdata", m_axis_tdata, ed);
                chk("out_tlast", TW'(m_axis_tlast), TW'(el));
                chk("out_tuser", TW'(m_axis_tuser), TW'(eu));
                chk("active_mask", TW'(active_mask), TW'(pm));
                chk("err_tlast", TW'(err_tlast), TW'(err_m));
                chk("beat_count", TW'(beat_count), TW'(bidx));
                chk("pkt_count", TW'(pkt_count), TW'(pkts));
                if (el) begin
                    open = 0;
                    pkts++;
                end else begin
                    bidx++;
                end
            end
            stall = m_axis_tvalid && !m_axis_tready;
            sd = m_axis_tdata;
            sl = m_axis_tlast;
            su = m_axis_tuser;
        end
    end

    initial begin : main
        int n;
        tests = 0; fails = 0;
        aresetn = 1'b0; ch_enable = '0; rprob = 100;
        cap1 = -1; first_v = -1; hs_first = -1; hs_last = -1; rdy1_seen = 0;
        for (int c = 0; c < N_CH; c++) vprob[c] = 100;

        repeat (2) @(negedge aclk);
        #3;
        chk("rst_m_tvalid", TW'(m_axis_tvalid), '0);
        chk("rst_s_tready", TW'(s_axis_tready), '0);
        chk("rst_counts", TW'({beat_count, pkt_count}), '0);
        chk("rst_err_mask", TW'({err_tlast, active_mask}), '0);
        chk("rst_m_tdata", m_axis_tdata, '0);
        aresetn = 1'b1;
        #1;
        chk("tready_before_first_edge", TW'(s_axis_tready), '0);

        // Channel subset 101, full rate
        @(negedge aclk); #2;
        ch_enable = 3'b101; rdy1_seen = 0; hs_first = -1;
        for (int b = 0; b < 49; b++) begin
            push_beat(0, b == 48);
            push_beat(2, b == 48);
        end
        mask_q.push_back(3'b101);
        drain("subset");
        chk("subset_pkt_count", TW'(pkt_count), TW'(1));
        chk("subset_beat_count", TW'(beat_count), '0);
        chk("subset_ch1_ready", TW'(rdy1_seen), '0);
        chk("subset_back_to_back", TW'(hs_last - hs_first), TW'(48));

        // Late channel 1
        ch_enable = 3'b111; cap1 = -1; first_v = -1;
        for (int b = 0; b < 8; b++) begin
            push_beat(0, b == 7);
            push_beat(2, b == 7);
        end
        mask_q.push_back(3'b111);
        repeat (5) @(negedge aclk);
        #2;
        for (int b = 0; b < 8; b++) push_beat(1, b == 7);
        drain("late");
        chk("late_first_valid_cycle", TW'(first_v), TW'(cap1 + 2));
        chk("late_pkt_count", TW'(pkt_count), TW'(2));

        // Backpressure: full stall first, then 50% ready
        rprob = 0;
        for (int b = 0; b < 64; b++)
            for (int c = 0; c < N_CH; c++) push_beat(c, b == 63);
        mask_q.push_back(3'b111);
        repeat (8) @(negedge aclk);
        #2;
        for (int c = 0; c < N_CH; c++) chk("bp_accepted_while_stalled", TW'(exp_in[c].size()), TW'(3));
        chk("bp_tready_full", TW'(s_axis_tready), '0);
        rprob = 50;
        for (int c = 0; c < N_CH; c++) vprob[c] = 70;
        drain("backpressure");
        chk("bp_pkt_count", TW'(pkt_count), TW'(3));

        // tlast mismatch: ch0 ends at beat 4, ch2 at beat 5
        rprob = 100;
        ch_enable = 3'b101;
        for (int b = 0; b < 4; b++) push_beat(0, b == 3);
        for (int b = 0; b < 5; b++) push_beat(2, b == 4);
        for (int b = 0; b < 3; b++) push_beat(0, b == 2);
        for (int b = 0; b < 2; b++) push_beat(2, b == 1);
        repeat (3) mask_q.push_back(3'b101);
        drain("mismatch");
        chk("mismatch_err_held", TW'(err_tlast), TW'(1));
        chk("mismatch_pkt_count", TW'(pkt_count), TW'(6));

        // Mask change 101 -> 111 mid-packet
        rprob = 60;
        for (int b = 0; b < 40; b++) begin
            push_beat(0, (b % 20) == 19);
            push_beat(2, (b % 20) == 19);
        end
        for (int b = 0; b < 20; b++) push_beat(1, b == 19);
        mask_q.push_back(3'b101);
        mask_q.push_back(3'b111);
        n = 0;
        while (n < 2000 && beat_count != 10) begin
            @(negedge aclk); #2;
            n++;
        end
        chk("maskchg_wait_timeout", TW'(n >= 2000), '0);
        ch_enable = 3'b111;
        drain("maskchg");
        chk("maskchg_pkt_count", TW'(pkt_count), TW'(8));

        // Reset mid-packet
        rprob = 100;
        for (int c = 0; c < N_CH; c++) vprob[c] = 100;
        for (int b = 0; b < 20; b++)
            for (int c = 0; c < N_CH; c++) push_beat(c, b == 19);
        mask_q.push_back(3'b111);
        n = 0;
        while (n < 2000 && beat_count != 7) begin
            @(negedge aclk); #2;
            n++;
        end
        chk("rst_mid_wait_timeout", TW'(n >= 2000), '0);
        #1;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_m_tvalid", TW'(m_axis_tvalid), '0);
        chk("rst_mid_s_tready", TW'(s_axis_tready), '0);
        chk("rst_mid_counts", TW'({beat_count, pkt_count}), '0);
        chk("rst_mid_err", TW'(err_tlast), '0);
        for (int c = 0; c < N_CH; c++) begin
            src_q[c].delete();
            exp_in[c].delete();
        end
        mask_q.delete();
        repeat (2) @(negedge aclk);
        #3;
        aresetn = 1'b1;
        #1;
        chk("rst_mid_tready_before_edge", TW'(s_axis_tready), '0);
        @(posedge aclk); #1;
        chk("rst_mid_tready_after_edge", TW'(s_axis_tready), TW'(3'b111));
        @(negedge aclk); #2;
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < N_CH; c++) push_beat(c, b == 9);
        mask_q.push_back(3'b111);
        drain("post_reset");
        chk("post_reset_pkt_count", TW'(pkt_count), TW'(1));
        chk("post_reset_beat_count", TW'(beat_count), '0);
        chk("post_reset_err", TW'(err_tlast), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
